// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the uart transmit path.
package uart_pkg;

  localparam int BYTE_W    = 8;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_st_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte buffer with a separate occupancy counter, registered
// full/empty flags and a sticky overflow flag.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  input  logic              ovf_clr,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   count_nxt;
  logic              push_ok, pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  // Read port is asynchronous on the pre-edge pointer: no write-through.
  assign rd_data = mem[rptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + (ADDR_W+1)'(1);
      2'b01:   count_nxt = count - (ADDR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + ADDR_W'(1);
      if (pop_ok)  rptr <= rptr + ADDR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == (ADDR_W+1)'(DEPTH));
      empty <= (count_nxt == '0);
      // A dropped byte outranks a clear in the same cycle.
      if (push && full)  overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart transmitter: pops one byte, strobes wr_en for a
// cycle, then waits for tx_busy to rise (bounded) and fall before the next.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int BUSY_WAIT = 4
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [BYTE_W-1:0] din,
  output logic              wr_en,
  input  logic              tx_busy
);

  localparam int WC_W = $clog2(BUSY_WAIT + 1);

  tx_st_e            state;
  logic [WC_W-1:0]   wait_cnt;
  logic [BYTE_W-1:0] rd_data;
  logic              pop;

  assign pop = (state == ST_IDLE) && !empty && !tx_busy;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk_50m),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .ovf_clr   (ovf_clr),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      din      <= '0;
      wr_en    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            din   <= rd_data;
            wr_en <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          wait_cnt <= '0;
          state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // A transmitter that never raises busy is treated as done.
          if (tx_busy)                                state    <= ST_WAIT_DONE;
          else if (wait_cnt == WC_W'(BUSY_WAIT - 1))  state    <= ST_IDLE;
          else                                        wait_cnt <= wait_cnt + WC_W'(1);
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
